// File: rtl/fifo_ctl_w1r1_pkg.sv
// Shared address-width derivation for the FIFO controller and its memw1r1 RAM.
// Both sides must call addr_width() so pointer and RAM address widths always agree.
package fifo_ctl_w1r1_pkg;

  // Ceiling-log2 ladder with a floor of 1: 2->1, 3..4->2, ..., 129..256->8.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ctl_w1r1_ptr_wrap.sv
// Modulo-DEPTH pointer incrementer; purely combinational, no backpressure.
// Wraps DEPTH-1 back to 0 so non-power-of-2 depths never address past the RAM.
module fifo_ptr_wrap #(
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] ptr_nxt
);

  assign ptr_nxt = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);

endmodule

// File: rtl/fifo_ctl_w1r1.sv
// FWFT FIFO controller driving an external memw1r1 RAM; read data is zero-latency from do_b.
// Upstream sees full/afull and drops (flagging ovf_err) pushes that cannot land; downstream is valid/ready.
module fifo_ctl_w1r1
  import fifo_ctl_w1r1_pkg::*;
#(
  parameter  int DEPTH        = 3,
  parameter  int WIDTH        = 72,
  parameter  int AFULL_THRESH = DEPTH - 1,
  localparam int ADDRWIDTH    = addr_width(DEPTH)
) (
  input  logic                 clk_a,
  input  logic                 rst_a_n,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 full,
  output logic                 afull,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [ADDRWIDTH:0]   count,
  output logic                 ovf_err,
  output logic [ADDRWIDTH-1:0] mem_addr_a,
  output logic [WIDTH-1:0]     mem_wen_a,
  output logic [WIDTH-1:0]     mem_di_a,
  output logic [ADDRWIDTH-1:0] mem_addr_b,
  input  logic [WIDTH-1:0]     mem_do_b
);

  localparam int CW = ADDRWIDTH + 1;

  if (DEPTH < 2 || DEPTH > 256) begin : g_depth_chk
    $error("fifo_ctl_w1r1: DEPTH out of range 2..256");
  end

  logic [ADDRWIDTH-1:0] wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [ADDRWIDTH-1:0] wr_ptr_nxt;
  logic [ADDRWIDTH-1:0] rd_ptr_nxt;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic                 pop;
  logic                 push_ok;
  logic                 wr_fire;

  assign full     = (cnt_q == CW'(DEPTH));
  assign afull    = (cnt_q >= CW'(AFULL_THRESH));
  assign rd_valid = (cnt_q != '0);
  assign count    = cnt_q;
  assign ovf_err  = ovf_q;

  // A full FIFO still takes a push when the head leaves in the same cycle:
  // the RAM read is combinational, so the vacated slot is reused at the edge.
  assign pop     = rd_valid & rd_ready;
  assign push_ok = wr_en & (~full | pop);
  assign wr_fire = push_ok & ~clr;

  assign mem_addr_a = wr_ptr;
  assign mem_wen_a  = {WIDTH{wr_fire}};
  assign mem_di_a   = wr_data;
  assign mem_addr_b = rd_ptr;
  assign rd_data    = mem_do_b;

  fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(ADDRWIDTH)) u_wr_wrap (
    .ptr     (wr_ptr),
    .ptr_nxt (wr_ptr_nxt)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(ADDRWIDTH)) u_rd_wrap (
    .ptr     (rd_ptr),
    .ptr_nxt (rd_ptr_nxt)
  );

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (wr_en & ~push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef ASSERT_ON
  always_ff @(posedge clk_a) begin
    if (rst_a_n) begin
      a_count_range : assert (cnt_q <= CW'(DEPTH));
      a_wr_en_known : assert (!$isunknown(wr_en));
      a_addr_a_range : assert ({1'b0, mem_addr_a} < CW'(DEPTH));
      a_addr_b_range : assert ({1'b0, mem_addr_b} < CW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctl_w1r1.sv
// Bench for fifo_ctl_w1r1 at DEPTH=5, WIDTH=8 with a behavioural RAM and a queue-based reference.
module tb_fifo_ctl_w1r1;

  localparam int DP = 5;
  localparam int WD = 8;
  localparam int AW = 3;

  logic          clk_a;
  logic          rst_a_n;
  logic          clr;
  logic          wr_en;
  logic [WD-1:0] wr_data;
  logic          full;
  logic          afull;
  logic          rd_valid;
  logic          rd_ready;
  logic [WD-1:0] rd_data;
  logic [AW:0]   count;
  logic          ovf_err;
  logic [AW-1:0] mem_addr_a;
  logic [WD-1:0] mem_wen_a;
  logic [WD-1:0] mem_di_a;
  logic [AW-1:0] mem_addr_b;
  logic [WD-1:0] mem_do_b;

  fifo_ctl_w1r1 #(.DEPTH(DP), .WIDTH(WD)) dut (
    .clk_a      (clk_a),
    .rst_a_n    (rst_a_n),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .afull      (afull),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .ovf_err    (ovf_err),
    .mem_addr_a (mem_addr_a),
    .mem_wen_a  (mem_wen_a),
    .mem_di_a   (mem_di_a),
    .mem_addr_b (mem_addr_b),
    .mem_do_b   (mem_do_b)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  // Attached memw1r1 stand-in: write on edge with full-word enable, combinational read.
  logic [WD-1:0] ram [DP];
  always @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      for (int i = 0; i < DP; i++) ram[i] <= '0;
    end else if (mem_wen_a == {WD{1'b1}} && mem_addr_a < AW'(DP)) begin
      ram[mem_addr_a] <= mem_di_a;
    end
  end
  assign mem_do_b = (mem_addr_b < AW'(DP)) ? ram[mem_addr_b] : '0;

  // Reference: FIFO contents as a queue, sticky overflow flag, accepted-push tally for the write address.
  logic [WD-1:0] mq [$];
  logic          m_ovf;
  int            m_pushes;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_pushes = 0;
  endtask

  // Called at a negedge: drive inputs, check pre-edge outputs, advance model at posedge.
  task automatic step(input logic wr, input logic [WD-1:0] d, input logic rdy, input logic c);
    logic e_full, e_pop, e_push;
    wr_en    = wr;
    wr_data  = d;
    rd_ready = rdy;
    clr      = c;
    #1;
    e_full = (mq.size() == DP);
    e_pop  = (mq.size() != 0) && rdy;
    e_push = wr && (!e_full || e_pop);
    chk("count", 32'(count), mq.size());
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("full", 32'(full), 32'(e_full));
    chk("afull", 32'(afull), 32'(mq.size() >= DP - 1));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (mq.size() != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    chk("mem_wen_a", 32'(mem_wen_a), (e_push && !c) ? 32'hFF : 32'h0);
    if (e_push && !c) chk("mem_addr_a", 32'(mem_addr_a), m_pushes % DP);
    chk("mem_addr_b_rng", 32'(mem_addr_b < AW'(DP)), 32'd1);
    @(posedge clk_a);
    if (c) begin
      model_reset();
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back(d);
        m_pushes++;
      end
      if (wr && !e_push) m_ovf = 1'b1;
    end
    @(negedge clk_a);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_a_n  = 1'b0;
    clr      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_wen", 32'(mem_wen_a), 0);
    @(negedge clk_a);
    rst_a_n = 1'b1;

    // Three pushes, nothing drained.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("three_count", 32'(count), 3);
    chk("three_head", 32'(rd_data), 32'h11);

    // Fill, drop one push, then flush.
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drop_ovf", 32'(ovf_err), 1);
    chk("drop_count", 32'(count), DP);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf", 32'(ovf_err), 0);

    // Push and pop together against a full FIFO, then drain.
    for (int i = 0; i < DP; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), DP);
    for (int i = 0; i < DP; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_ovf", 32'(ovf_err), 0);

    // Thirteen single-item round trips exercise pointer wrap.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Push into empty with ready held high.
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_full", 32'(full), 0);
    model_reset();
    @(negedge clk_a);
    rst_a_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctl_w1r1.md
Name: fifo_ctl_w1r1

Overview:
- Synchronous FIFO controller that sits directly in front of a memw1r1 dual-port RAM.
- Drives the RAM write port (addr_a/wen_a/di_a) and read address (addr_b), and consumes the RAM's combinational read data (do_b).
- Presents a push/full write interface upstream and a first-word-fall-through valid/ready read interface downstream.
- Used for PCI data buffering where the RAM is instantiated separately by the parent.

Parameters:
- DEPTH, 3, number of FIFO entries; must equal the attached RAM's NUMWORDS; legal range 2..256.
- WIDTH, 72, data width; must equal the RAM's NUMBITS.
- ADDRWIDTH, derived, same ceiling-log2 ladder as the RAM (1 for DEPTH 2, 2 for 3..4, ... 8 for 129..256); never overridden.
- AFULL_THRESH, DEPTH-1, count at or above which afull asserts.

Ports:
- clk_a  in  1  sole clock; all state on posedge.
- rst_a_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: empties the FIFO and clears ovf_err.
- wr_en  in  1  push strobe.
- wr_data  in  WIDTH  push data.
- full  out  1  count==DEPTH.
- afull  out  1  count>=AFULL_THRESH.
- rd_valid  out  1  FIFO non-empty; rd_data valid.
- rd_ready  in  1  downstream accepts rd_data when rd_valid.
- rd_data  out  WIDTH  head entry (mem_do_b passthrough).
- count  out  ADDRWIDTH+1  current occupancy.
- ovf_err  out  1  sticky: push was dropped.
- mem_addr_a  out  ADDRWIDTH  RAM write address (= wr_ptr).
- mem_wen_a  out  WIDTH  all ones on an accepted push, else all zeros.
- mem_di_a  out  WIDTH  = wr_data.
- mem_addr_b  out  ADDRWIDTH  RAM read address (= rd_ptr).
- mem_do_b  in  WIDTH  RAM combinational read data.

Behaviour:
- Reset (async, rst_a_n low): wr_ptr=0, rd_ptr=0, count=0, ovf_err=0. Outputs: full=0, afull=0 (1 only if AFULL_THRESH==0), rd_valid=0, mem_wen_a=0.
- pop = rd_valid & rd_ready.
- push_ok = wr_en & (!full | pop). A push against a full FIFO is accepted only when a pop occurs in the same cycle.
- Dropped push (wr_en & !push_ok): RAM is not written, state is unchanged, ovf_err<=1 at the next edge.
- mem_wen_a = {WIDTH{push_ok & !clr}}. This is combinational from wr_en, rd_ready and registered state. The RAM captures the data on the same edge.
- wr_ptr advances on push_ok and rd_ptr advances on pop. Both wrap from DEPTH-1 to 0; non-power-of-2 DEPTH is legal. Pointers never address >= DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. full, afull and rd_valid are decoded from registered count.
- Latency:
  - Data pushed at edge N is visible on rd_data with rd_valid=1 after edge N (zero-cycle read, since RAM read is combinational).
  - A pop at edge N exposes the next entry after edge N.
- Push and pop on an empty FIFO: impossible, since rd_valid=0 so pop=0; only the push is taken.
- Push and pop on a full FIFO: both taken; count stays DEPTH; the new data lands at the slot being vacated (wr_ptr==rd_ptr).
  - Legal because the pop reads combinationally before the edge and the write lands at the edge.
- clr:
  - Highest priority: pointers and count go to 0, ovf_err goes to 0.
  - Any concurrent push is suppressed (mem_wen_a=0) and does not set ovf_err. A concurrent pop is discarded.
- rd_data is undefined-but-stable when rd_valid=0; no requirement on its value.
- Reset mid-operation: all contents are logically lost. The RAM resets to zero on the same rst_a_n.
- Assertions (under ASSERT_ON):
  - count<=DEPTH.
  - wr_en never X out of reset.
  - mem_addr_a<DEPTH and mem_addr_b<DEPTH.

Decomposition:
- No shared package needed.
- ADDRWIDTH ladder goes in a common macro/function include shared with the RAM, so both use identical derivation.
- One optional sub-module, fifo_ptr_wrap: a modulo-DEPTH incrementer, instantiated twice (write and read pointers).
- The RAM is not instantiated inside this block.

Test Plan:
- DEPTH=5, WIDTH=8: reset, push 0x11,0x22,0x33 on consecutive cycles with rd_ready=0.
  -> count=3; rd_valid=1; rd_data=0x11; mem_wen_a=0xFF only on the three push cycles.
- Fill DEPTH=5, then push 0x99 with rd_ready=0.
  -> push dropped, full=1, count=5, ovf_err=1 from the next cycle. Then clr -> count=0, ovf_err=0, rd_valid=0.
- Full FIFO, wr_en=1 with data 0xAB and rd_ready=1 for 1 cycle.
  -> count stays 5, head advances. 0xAB is read out as the 5th subsequent pop, and ovf_err stays 0.
- Wrap: push/pop 13 items one at a time with DEPTH=5.
  -> output order matches input exactly; mem_addr_a sequence is 0,1,2,3,4,0,1,...; no address >=5.
- Empty FIFO: push 0x5A at edge N with rd_ready held 1.
  -> rd_valid=1 and rd_data=0x5A in cycle N+1; popped at edge N+1; count returns to 0.
- Assert rst_a_n low asynchronously mid-burst (count=3).
  -> rd_valid, full and count go to 0 immediately, without waiting for a clock edge. After release, the first push is read back correctly from address 0.
